// File: rtl/spi_pkg.sv
// Shared definitions for the SPI peripheral: FSM state encoding, byte size
// and helpers that decode the SPI mode number into CPOL / CPHA.
package spi_pkg;

  localparam int BITS_PER_BYTE = 8;
  localparam int CNT_W         = 3;

  // Bit positions inside the 2-bit SPI mode number.
  localparam int MODE_CPOL_BIT = 1;
  localparam int MODE_CPHA_BIT = 0;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_ACTIVE = 1'b1;

  // Clock polarity: idle level of SCLK.
  function automatic logic mode_cpol(input int mode);
    logic [1:0] m;
    m = mode[1:0];
    return m[MODE_CPOL_BIT];
  endfunction

  // Clock phase: 0 = sample on leading edge, 1 = sample on trailing edge.
  function automatic logic mode_cpha(input int mode);
    logic [1:0] m;
    m = mode[1:0];
    return m[MODE_CPHA_BIT];
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous pin. The reset value is a port
// so each pin can come out of reset at its idle bus level.
module spi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_peripheral.sv
// SPI peripheral (target) with a one-entry TX byte buffer.
// All SPI pins are oversampled in the r_clk domain; SCLK must be at most r_clk/8.
// Optional feature macro: SPI_PERIPHERAL_OVERRUN_EN adds r_rx_ack / w_overrun.
//
// TX handshake: a byte is written on any r_clk rising edge where r_tx_valid and
// w_tx_ready are both high; w_tx_ready is high exactly when the buffer is empty,
// and r_tx_valid is ignored while w_tx_ready is low. RX has no back-pressure:
// w_rx_valid is a single-cycle strobe qualifying w_rx_data.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int         SPI_MODE  = 0,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic       r_clk,
  input  logic       r_reset,
  input  logic       r_sclk,
  input  logic       r_cs_n,
  input  logic       r_mosi,
  output logic       w_miso,
  output logic       w_miso_oe,
  input  logic [7:0] r_tx_data,
  input  logic       r_tx_valid,
  output logic       w_tx_ready,
  output logic [7:0] w_rx_data,
  output logic       w_rx_valid,
  output state_t     w_state
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  ,
  input  logic       r_rx_ack,
  output logic       w_overrun
`endif
);

  localparam logic             CPOL     = mode_cpol(SPI_MODE);
  localparam logic             CPHA     = mode_cpha(SPI_MODE);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_BYTE - 1);

  logic s_sclk, s_cs_n, s_mosi;

  spi_sync u_sync_sclk (.clk(r_clk), .rst_n(r_reset), .rst_val(CPOL), .d(r_sclk), .q(s_sclk));
  spi_sync u_sync_cs   (.clk(r_clk), .rst_n(r_reset), .rst_val(1'b1), .d(r_cs_n), .q(s_cs_n));
  spi_sync u_sync_mosi (.clk(r_clk), .rst_n(r_reset), .rst_val(1'b0), .d(r_mosi), .q(s_mosi));

  logic       sclk_d, cs_d;
  logic [1:0] warm;
  logic       edges_on;

  // Previous synchronized levels for edge detection, plus a short warm-up
  // after reset: the synchronizers start at the idle bus level, so a CS pin
  // already held low would look like a fresh fall. Edges are ignored until
  // the chain has flushed and cs_d reflects the real pin.
  always_ff @(posedge r_clk or negedge r_reset) begin
    if (!r_reset) begin
      sclk_d <= CPOL;
      cs_d   <= 1'b1;
      warm   <= 2'd0;
    end else begin
      sclk_d <= s_sclk;
      cs_d   <= s_cs_n;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  assign edges_on = (warm == 2'd3);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  assign sclk_rise   = edges_on &  s_sclk & ~sclk_d;
  assign sclk_fall   = edges_on & ~s_sclk &  sclk_d;
  assign cs_fall     = edges_on & ~s_cs_n &  cs_d;
  assign cs_rise     = edges_on &  s_cs_n & ~cs_d;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       tx_sr;
  logic [6:0]       rx_sr;
  logic             miso;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       tx_buf;
  logic             buf_full;

  logic       active, byte_start, byte_done, tx_write;
  logic [7:0] load_val;

  assign active     = (state == ST_ACTIVE);
  assign byte_done  = active && !cs_rise && sample_edge && (bit_cnt == LAST_BIT);
  assign byte_start = (!active && cs_fall) || byte_done;
  assign load_val   = buf_full ? tx_buf : IDLE_BYTE;
  assign tx_write   = r_tx_valid && !buf_full;

  // FSM and shift datapath: CS rise always aborts; CS fall starts a byte;
  // sample edges collect MOSI, shift edges advance MISO.
  always_ff @(posedge r_clk or negedge r_reset) begin
    if (!r_reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      miso     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (cs_rise) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        miso    <= 1'b0;
      end else if (!active) begin
        if (cs_fall) begin
          state   <= ST_ACTIVE;
          bit_cnt <= '0;
          tx_sr   <= load_val;
          if (!CPHA) miso <= load_val[7];
        end
      end else begin
        if (sample_edge) begin
          rx_sr <= {rx_sr[5:0], s_mosi};
          if (bit_cnt == LAST_BIT) begin
            // Byte boundary: deliver RX and reload TX so the next byte can
            // follow without a CS toggle.
            bit_cnt  <= '0;
            rx_data  <= {rx_sr, s_mosi};
            rx_valid <= 1'b1;
            tx_sr    <= load_val;
            if (!CPHA) miso <= load_val[7];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        if (shift_edge) begin
          if (CPHA) begin
            miso  <= tx_sr[7];
            tx_sr <= {tx_sr[6:0], 1'b0};
          end else if (bit_cnt != '0) begin
            // With CPHA=0 bit 7 is already on the line; the trailing edge
            // right after a byte boundary must not shift the fresh byte.
            miso  <= tx_sr[6];
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
      end
    end
  end

  // One-entry TX buffer: a write can only land while empty, so a write that
  // coincides with a byte start sees the old (empty) contents go to the
  // shift register and the new byte stays buffered.
  always_ff @(posedge r_clk or negedge r_reset) begin
    if (!r_reset) begin
      tx_buf   <= '0;
      buf_full <= 1'b0;
    end else if (tx_write) begin
      tx_buf   <= r_tx_data;
      buf_full <= 1'b1;
    end else if (byte_start) begin
      buf_full <= 1'b0;
    end
  end

  assign w_miso     = miso;
  assign w_miso_oe  = active;
  assign w_tx_ready = !buf_full;
  assign w_rx_data  = rx_data;
  assign w_rx_valid = rx_valid;
  assign w_state    = state;

`ifdef SPI_PERIPHERAL_OVERRUN_EN
  logic rx_pending, overrun;

  // Track whether the last delivered byte was acknowledged; flag a new byte
  // arriving on top of an unacknowledged one.
  always_ff @(posedge r_clk or negedge r_reset) begin
    if (!r_reset) begin
      rx_pending <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= byte_done && rx_pending && !r_rx_ack;
      if (byte_done)     rx_pending <= 1'b1;
      else if (r_rx_ack) rx_pending <= 1'b0;
    end
  end

  assign w_overrun = overrun;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: one instance per SPI mode (0..3), a bit-banged
// SPI controller, a TX-buffer model and an RX scoreboard.
module tb_spi_peripheral;
  import spi_pkg::*;

  // ---------------- clock / reset ----------------
  logic r_clk = 1'b0;
  logic r_reset;
  always #5 r_clk = ~r_clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT array ----------------
  logic [3:0] sclk, cs_n, mosi, tx_valid;
  logic [3:0] miso, miso_oe, tx_ready, rx_valid;
  logic [7:0] tx_data [4];
  logic [7:0] rx_data [4];
  state_t     st [4];
`ifdef SPI_PERIPHERAL_OVERRUN_EN
  logic [3:0] rx_ack, overrun;
  assign rx_ack = rx_valid;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_peripheral #(.SPI_MODE(g), .IDLE_BYTE(8'h00)) u_dut (
      .r_clk      (r_clk),
      .r_reset    (r_reset),
      .r_sclk     (sclk[g]),
      .r_cs_n     (cs_n[g]),
      .r_mosi     (mosi[g]),
      .w_miso     (miso[g]),
      .w_miso_oe  (miso_oe[g]),
      .r_tx_data  (tx_data[g]),
      .r_tx_valid (tx_valid[g]),
      .w_tx_ready (tx_ready[g]),
      .w_rx_data  (rx_data[g]),
      .w_rx_valid (rx_valid[g]),
      .w_state    (st[g])
`ifdef SPI_PERIPHERAL_OVERRUN_EN
      ,
      .r_rx_ack   (rx_ack[g]),
      .w_overrun  (overrun[g])
`endif
    );
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q[$];            // {mode, byte} expected on w_rx_data
  logic       model_full [4];
  logic [7:0] model_buf  [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reply the controller must see for a byte starting now.
  function automatic logic [7:0] take_reply(input int m);
    if (model_full[m]) begin
      model_full[m] = 1'b0;
      return model_buf[m];
    end
    return 8'h00;
  endfunction

  // Compare process: every strobe must be single-cycle and match the queue.
  initial begin
    logic [3:0] prev_valid;
    logic [9:0] e;
    prev_valid = '0;
    forever begin
      @(negedge r_clk);
      if (r_reset) begin
        for (int m = 0; m < 4; m++) begin
          if (rx_valid[m]) begin
            check("rx_strobe_single", {31'd0, prev_valid[m]}, 32'd0);
            if (exp_q.size() == 0) begin
              check("rx_unexpected_strobe", exp_q.size(), 32'd1);
            end else begin
              e = exp_q.pop_front();
              check("rx_byte", {22'd0, m[1:0], rx_data[m]}, {22'd0, e});
            end
          end
        end
      end
      prev_valid = rx_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge r_clk);
  endtask

  task automatic tx_write(input int m, input logic [7:0] d);
    int t;
    t = 0;
    while (!tx_ready[m] && t < 300) begin
      wait_cyc(1);
      t++;
    end
    check("tx_write_ready", {31'd0, tx_ready[m]}, 32'd1);
    tx_data[m]  = d;
    tx_valid[m] = 1'b1;
    wait_cyc(1);
    tx_valid[m] = 1'b0;
    model_full[m] = 1'b1;
    model_buf[m]  = d;
  endtask

  task automatic try_write_blocked(input int m, input logic [7:0] d);
    tx_data[m]  = d;
    tx_valid[m] = 1'b1;
    wait_cyc(3);
    tx_valid[m] = 1'b0;
    check("tx_ready_while_full", {31'd0, tx_ready[m]}, 32'd0);
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    wait_cyc(6);
    check("miso_oe_active", {31'd0, miso_oe[m]}, 32'd1);
  endtask

  task automatic cs_high(input int m, input int hp);
    wait_cyc(hp);
    cs_n[m] = 1'b1;
    wait_cyc(6);
    check("miso_oe_idle", {31'd0, miso_oe[m]}, 32'd0);
  endtask

  // Clock nbits bits MSB-first. 'live' means the DUT is in a transfer.
  task automatic spi_byte(input int m, input int hp, input logic [7:0] tx,
                          input int nbits, input bit live, output logic [7:0] rx);
    logic cpol, cpha;
    logic [7:0] exp_reply;
    cpol = m[1];
    cpha = m[0];
    rx = 8'h00;
    exp_reply = 8'h00;
    if (live) begin
      exp_reply = take_reply(m);
      if (nbits == 8) exp_q.push_back({m[1:0], tx});
    end
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha) begin
        mosi[m] = tx[i];
        wait_cyc(hp);
        sclk[m] = ~cpol;
        rx[i] = miso[m];
        wait_cyc(hp);
        sclk[m] = cpol;
      end else begin
        wait_cyc(hp);
        sclk[m] = ~cpol;
        mosi[m] = tx[i];
        wait_cyc(hp);
        sclk[m] = cpol;
        rx[i] = miso[m];
      end
    end
    if (live && nbits == 8) check("miso_reply", {24'd0, rx}, {24'd0, exp_reply});
  endtask

  task automatic check_reset_values();
    for (int m = 0; m < 4; m++) begin
      check("rst_miso",     {31'd0, miso[m]},     32'd0);
      check("rst_miso_oe",  {31'd0, miso_oe[m]},  32'd0);
      check("rst_tx_ready", {31'd0, tx_ready[m]}, 32'd1);
      check("rst_rx_valid", {31'd0, rx_valid[m]}, 32'd0);
      check("rst_rx_data",  {24'd0, rx_data[m]},  32'd0);
      check("rst_state",    {31'd0, st[m]},       {31'd0, ST_IDLE});
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] r1, r2;

  initial begin
    sclk     = 4'b1100;
    cs_n     = 4'hF;
    mosi     = 4'h0;
    tx_valid = 4'h0;
    for (int m = 0; m < 4; m++) begin
      tx_data[m]    = 8'h00;
      model_full[m] = 1'b0;
      model_buf[m]  = 8'h00;
    end
    r_reset = 1'b0;
    wait_cyc(5);
    check_reset_values();
    r_reset = 1'b1;
    wait_cyc(5);

    // Mode 0 basic exchange.
    tx_write(0, 8'h3C);
    check("tx_ready_after_write", {31'd0, tx_ready[0]}, 32'd0);
    cs_low(0);
    spi_byte(0, 4, 8'hC1, 8, 1'b1, r1);
    check("basic_reply_3c", {24'd0, r1}, 32'h3C);
    cs_high(0, 4);
    check("basic_tx_ready", {31'd0, tx_ready[0]}, 32'd1);

    // All four modes.
    for (int m = 0; m < 4; m++) begin
      tx_write(m, 8'hA5);
      cs_low(m);
      spi_byte(m, 4, 8'h5A, 8, 1'b1, r1);
      check("mode_reply_a5", {24'd0, r1}, 32'hA5);
      cs_high(m, 4);
    end

    // Empty buffer: idle byte goes out, ready stays high.
    cs_low(0);
    spi_byte(0, 4, 8'hFF, 8, 1'b1, r1);
    check("empty_reply_idle", {24'd0, r1}, 32'h00);
    check("empty_tx_ready", {31'd0, tx_ready[0]}, 32'd1);
    cs_high(0, 4);

    // Back-to-back bytes under one CS, buffer refilled mid-first-byte.
    foreach (r1[k]) begin end
    for (int m = 0; m < 4; m += 3) begin
      cs_low(m);
      fork
        begin
          spi_byte(m, 4, 8'h01, 8, 1'b1, r1);
          spi_byte(m, 4, 8'h02, 8, 1'b1, r2);
        end
        begin
          wait_cyc(24);
          tx_write(m, 8'h80);
        end
      join
      check("b2b_first_idle", {24'd0, r1}, 32'h00);
      check("b2b_second_80", {24'd0, r2}, 32'h80);
      cs_high(m, 4);
    end

    // Writes while the buffer is full are dropped.
    tx_write(1, 8'h96);
    try_write_blocked(1, 8'h11);
    cs_low(1);
    spi_byte(1, 5, 8'h3E, 8, 1'b1, r1);
    check("blocked_write_kept_96", {24'd0, r1}, 32'h96);
    cs_high(1, 5);

    // CS abort after 5 bits: no strobe, buffer untouched.
    cs_low(0);
    spi_byte(0, 4, 8'hB3, 5, 1'b1, r1);
    tx_write(0, 8'h5E);
    cs_high(0, 4);
    check("abort_buffer_kept", {31'd0, tx_ready[0]}, 32'd0);
    cs_low(0);
    spi_byte(0, 4, 8'h77, 8, 1'b1, r1);
    check("after_abort_reply", {24'd0, r1}, 32'h5E);
    cs_high(0, 4);

    // Reset in the middle of a byte with a byte buffered.
    cs_low(0);
    spi_byte(0, 4, 8'hAB, 4, 1'b1, r1);
    tx_write(0, 8'h66);
    r_reset = 1'b0;
    wait_cyc(3);
    check_reset_values();
    for (int m = 0; m < 4; m++) model_full[m] = 1'b0;
    r_reset = 1'b1;
    wait_cyc(4);
    // CS still low from before reset: must not restart a transfer.
    spi_byte(0, 4, 8'hC3, 8, 1'b0, r1);
    check("no_restart_state", {31'd0, st[0]}, {31'd0, ST_IDLE});
    check("no_restart_oe", {31'd0, miso_oe[0]}, 32'd0);
    cs_high(0, 4);
    cs_low(0);
    spi_byte(0, 4, 8'h12, 8, 1'b1, r1);
    check("post_reset_reply", {24'd0, r1}, 32'h00);
    cs_high(0, 4);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      int m, hp, nb;
      m  = $urandom_range(0, 3);
      hp = $urandom_range(4, 7);
      nb = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) tx_write(m, 8'($urandom));
      cs_low(m);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 9) == 0) begin
          spi_byte(m, hp, 8'($urandom), $urandom_range(1, 7), 1'b1, r1);
          break;
        end
        spi_byte(m, hp, 8'($urandom), 8, 1'b1, r1);
      end
      cs_high(m, hp);
    end

    wait_cyc(20);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
